// File: rtl/ycbcr_block_buffer.sv
// Ping-pong block buffer: packs N rows of Y/Cb/Cr into NxN blocks and drains them
// over valid/ready, with optional level shift and transpose on the read path.
module ycbcr_block_buffer #(
    parameter int N           = 8,
    parameter int LEVEL_SHIFT = 1,
    parameter int TRANSPOSE   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [8*N-1:0]   i_luma,
    input  logic [8*N-1:0]   i_cb,
    input  logic [8*N-1:0]   i_cr,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [8*N-1:0]   o_luma,
    output logic [8*N-1:0]   o_cb,
    output logic [8*N-1:0]   o_cr,
    output logic [2:0]       o_row,
    output logic             o_sob,
    output logic             o_eob,
    output logic             o_overflow
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    bank_state_t bankState_q [2];
    bank_state_t bankState_d [2];
    logic        wrBank_q, wrBank_d;
    logic [2:0]  wrRow_q, wrRow_d;
    logic        rdBank_q, rdBank_d;
    logic [2:0]  rdRow_q, rdRow_d;
    logic        overflow_q, overflow_d;

    logic [8*N-1:0] yMem_q  [2*N];
    logic [8*N-1:0] cbMem_q [2*N];
    logic [8*N-1:0] crMem_q [2*N];

    logic rdFire, rdLast, wrFree, wrAccept;

    assign o_valid  = (bankState_q[rdBank_q] == FULL);
    assign rdFire   = o_valid && i_ready;
    assign rdLast   = rdFire && (rdRow_q == 3'(N-1));
    // A full write bank still accepts when its last beat is leaving this very cycle.
    assign wrFree   = (bankState_q[wrBank_q] != FULL) || (rdLast && (rdBank_q == wrBank_q));
    assign wrAccept = i_valid && wrFree;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bankState_q[0] <= EMPTY;
            bankState_q[1] <= EMPTY;
            wrBank_q       <= 1'b0;
            wrRow_q        <= '0;
            rdBank_q       <= 1'b0;
            rdRow_q        <= '0;
            overflow_q     <= 1'b0;
        end else begin
            bankState_q    <= bankState_d;
            wrBank_q       <= wrBank_d;
            wrRow_q        <= wrRow_d;
            rdBank_q       <= rdBank_d;
            rdRow_q        <= rdRow_d;
            overflow_q     <= overflow_d;
        end
    end

    // Read retire is applied first so a same-cycle write into the freed bank wins.
    always_comb begin
        bankState_d = bankState_q;
        wrBank_d    = wrBank_q;
        wrRow_d     = wrRow_q;
        rdBank_d    = rdBank_q;
        rdRow_d     = rdRow_q;
        overflow_d  = overflow_q;
        if (rdFire) begin
            if (rdRow_q == 3'(N-1)) begin
                rdRow_d               = '0;
                rdBank_d              = ~rdBank_q;
                bankState_d[rdBank_q] = EMPTY;
            end else begin
                rdRow_d = rdRow_q + 3'd1;
            end
        end
        if (i_valid) begin
            if (wrFree) begin
                if (wrRow_q == 3'(N-1)) begin
                    bankState_d[wrBank_q] = FULL;
                    wrRow_d               = '0;
                    wrBank_d              = ~wrBank_q;
                end else begin
                    bankState_d[wrBank_q] = FILLING;
                    wrRow_d               = wrRow_q + 3'd1;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wrAccept) begin
            yMem_q[{wrBank_q, wrRow_q}]  <= i_luma;
            cbMem_q[{wrBank_q, wrRow_q}] <= i_cb;
            crMem_q[{wrBank_q, wrRow_q}] <= i_cr;
        end
    end

    function automatic logic [7:0] shiftSample(input logic [7:0] s);
        return (LEVEL_SHIFT != 0) ? {~s[7], s[6:0]} : s;
    endfunction

    always_comb begin
        o_luma = '0;
        o_cb   = '0;
        o_cr   = '0;
        if (o_valid) begin
            for (int c = 0; c < N; c++) begin
                if (TRANSPOSE != 0) begin
                    o_luma[8*c +: 8] = shiftSample(yMem_q[{rdBank_q, 3'(c)}][{rdRow_q, 3'b000} +: 8]);
                    o_cb[8*c +: 8]   = shiftSample(cbMem_q[{rdBank_q, 3'(c)}][{rdRow_q, 3'b000} +: 8]);
                    o_cr[8*c +: 8]   = shiftSample(crMem_q[{rdBank_q, 3'(c)}][{rdRow_q, 3'b000} +: 8]);
                end else begin
                    o_luma[8*c +: 8] = shiftSample(yMem_q[{rdBank_q, rdRow_q}][8*c +: 8]);
                    o_cb[8*c +: 8]   = shiftSample(cbMem_q[{rdBank_q, rdRow_q}][8*c +: 8]);
                    o_cr[8*c +: 8]   = shiftSample(crMem_q[{rdBank_q, rdRow_q}][8*c +: 8]);
                end
            end
        end
    end

    assign o_row      = rdRow_q;
    assign o_sob      = o_valid && (rdRow_q == 3'd0);
    assign o_eob      = o_valid && (rdRow_q == 3'(N-1));
    assign o_overflow = overflow_q;

endmodule
